// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state encoding, config record and PE-width constants for the CONV sequencer
package conv_seq_pkg;
  localparam int NUM_PE_C = 16;
  localparam int CNT_W_C = 16;
  localparam logic [NUM_PE_C-1:0] PE_ALL_ONES = '1;
  typedef enum logic [2:0] {IDLE, LD_IFM, LD_WGT, PRIME, RUN, FLUSH, WAIT_OFM, FIN} seq_state_e;
  typedef struct packed {
    logic [CNT_W_C-1:0] ifm_words;
    logic [CNT_W_C-1:0] wgt_words;
    logic [CNT_W_C-1:0] win_len;
    logic [CNT_W_C-1:0] num_win;
  } seq_cfg_t;
endpackage

// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if: host load stream, sub-top control pins and OFM handshake of the sequencer
interface conv_layer_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int NUM_PE = 16,
  parameter int CNT_W = 16
);
  logic start;
  logic [CNT_W-1:0] cfg_ifm_words;
  logic [CNT_W-1:0] cfg_wgt_words;
  logic [CNT_W-1:0] cfg_win_len;
  logic [CNT_W-1:0] cfg_num_win;
  logic ld_valid;
  logic ld_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic we_ifm;
  logic we_weight;
  logic cal_start;
  logic [NUM_PE-1:0] pe_finish;
  logic [NUM_PE-1:0] pe_reset;
  logic [NUM_PE-1:0] pe_valid;
  logic ofm_valid;
  logic ofm_ready;
  logic busy;
  logic done;
  modport master (
    input start, cfg_ifm_words, cfg_wgt_words, cfg_win_len, cfg_num_win, ld_valid, pe_valid, ofm_ready,
    output ld_ready, wr_addr, we_ifm, we_weight, cal_start, pe_finish, pe_reset, ofm_valid, busy, done
  );
  modport slave (
    output start, cfg_ifm_words, cfg_wgt_words, cfg_win_len, cfg_num_win, ld_valid, pe_valid, ofm_ready,
    input ld_ready, wr_addr, we_ifm, we_weight, cal_start, pe_finish, pe_reset, ofm_valid, busy, done
  );
endinterface

// File: rtl/seq_cnt.sv
// seq_cnt: clearable up-counter with a terminal flag raised when the count equals last
module seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         term
);
  always_ff @(posedge clk)
    cnt <= (!reset_n || clr) ? '0 : en ? cnt + W'(1) : cnt;
  assign term = cnt == last;
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: loads IFM/weight BRAMs, frames PE windows and hands OFM vectors downstream.
// Defining CONV_SEQ_PERF_EN adds saturating RUN-cycle and OFM-stall counters.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_PE = NUM_PE_C,
  parameter int CNT_W = CNT_W_C
) (
  input logic clk,
  input logic reset_n,
  conv_layer_sequencer_if.master bus
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] perf_run_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);
  localparam logic [NUM_PE-1:0] ALL = '1;
  seq_state_e state, state_nxt;
  seq_cfg_t cfg;
  logic ld_hs, ofm_hs, all_valid, idx_term, cyc_term, win_term;
  logic [CNT_W-1:0] idx, cyc, win;
  logic unused_cnt;
  assign unused_cnt = ^{cyc, win};
  assign all_valid = &bus.pe_valid;
  assign ld_hs = bus.ld_valid && (state == LD_IFM || state == LD_WGT);
  assign ofm_hs = state == WAIT_OFM && all_valid && bus.ofm_ready;
  assign bus.wr_addr = ADDR_W'(idx);
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    state <= !reset_n ? IDLE : state_nxt;
    cfg <= !reset_n ? '0 : (state == IDLE && bus.start) ?
      '{bus.cfg_ifm_words, bus.cfg_wgt_words, bus.cfg_win_len, bus.cfg_num_win} : cfg;
  end
  seq_cnt #(.W(CNT_W)) u_idx (
    .clk(clk), .reset_n(reset_n), .clr(state == IDLE || (ld_hs && idx_term)), .en(ld_hs),
    .last(state == LD_WGT ? cfg.wgt_words - CNT_W'(1) : cfg.ifm_words - CNT_W'(1)),
    .cnt(idx), .term(idx_term)
  );
  seq_cnt #(.W(CNT_W)) u_cyc (
    .clk(clk), .reset_n(reset_n), .clr(state != RUN), .en(1'b1),
    .last(cfg.win_len - CNT_W'(1)), .cnt(cyc), .term(cyc_term)
  );
  seq_cnt #(.W(CNT_W)) u_win (
    .clk(clk), .reset_n(reset_n), .clr(state == IDLE), .en(ofm_hs),
    .last(cfg.num_win - CNT_W'(1)), .cnt(win), .term(win_term)
  );
  always_comb begin
    state_nxt = state;
    bus.ld_ready = 1'b0;
    bus.we_ifm = 1'b0;
    bus.we_weight = 1'b0;
    bus.cal_start = 1'b0;
    bus.pe_finish = '0;
    bus.pe_reset = '0;
    bus.ofm_valid = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: state_nxt = bus.start ? LD_IFM : IDLE;
      LD_IFM: begin
        bus.ld_ready = 1'b1;
        bus.we_ifm = ld_hs;
        state_nxt = (ld_hs && idx_term) ? LD_WGT : LD_IFM;
      end
      LD_WGT: begin
        bus.ld_ready = 1'b1;
        bus.we_weight = ld_hs;
        state_nxt = !(ld_hs && idx_term) ? LD_WGT :
                    (cfg.win_len == '0 || cfg.num_win == '0) ? FIN : PRIME;
      end
      PRIME: begin
        bus.cal_start = 1'b1;
        bus.pe_reset = ALL;
        state_nxt = RUN;
      end
      RUN: begin
        bus.cal_start = 1'b1;
        state_nxt = cyc_term ? FLUSH : RUN;
      end
      FLUSH: begin
        bus.pe_finish = ALL;
        state_nxt = WAIT_OFM;
      end
      WAIT_OFM: begin
        bus.ofm_valid = all_valid;
        bus.pe_reset = ofm_hs ? ALL : '0;
        state_nxt = !ofm_hs ? WAIT_OFM : win_term ? FIN : RUN;
      end
      FIN: begin
        bus.done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk)
    if (!reset_n || (state == IDLE && bus.start)) begin
      perf_run_cyc <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state == RUN && !(&perf_run_cyc)) perf_run_cyc <= perf_run_cyc + 32'd1;
      if (bus.ofm_valid && !bus.ofm_ready && !(&perf_stall_cyc)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed checks of load, window framing, stalls, reset abort and skip path
module tb_conv_layer_sequencer;
  import conv_seq_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int outs = 0;
  always #5 clk = ~clk;
  conv_layer_sequencer_if bus ();
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_run_cyc, perf_stall_cyc;
  conv_layer_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus),
    .perf_run_cyc(perf_run_cyc), .perf_stall_cyc(perf_stall_cyc));
`else
  conv_layer_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic start_pass(input int ifm, input int wgt, input int win, input int nw);
    bus.cfg_ifm_words = 16'(ifm);
    bus.cfg_wgt_words = 16'(wgt);
    bus.cfg_win_len = 16'(win);
    bus.cfg_num_win = 16'(nw);
    bus.ld_valid = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    #1;
  endtask
  task automatic skip_load(input int words);
    repeat (words) tick;
    bus.ld_valid = 1'b0;
    #1;
  endtask
  task automatic window(input int exp_run, input int partial, input int stall);
    int n = 0;
    int bad = 0;
    int held = 0;
    while (bus.cal_start === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    chk("run_len", n, exp_run);
    chk("flush_finish", bus.pe_finish, PE_ALL_ONES);
    tick;
    chk("finish_one_cycle", bus.pe_finish, 0);
    bus.pe_valid = 16'h7FFF;
    bus.ofm_ready = 1'b1;
    repeat (partial) begin
      #1;
      if (bus.ofm_valid !== 1'b0) bad++;
      tick;
    end
    if (partial > 0) chk("partial_pe_valid", bad, 0);
    bus.pe_valid = PE_ALL_ONES;
    bus.ofm_ready = 1'b0;
    repeat (stall) begin
      #1;
      if (bus.ofm_valid === 1'b1 && bus.cal_start === 1'b0 && bus.pe_reset === 16'h0) held++;
      tick;
    end
    if (stall > 0) chk("stall_hold", held, stall);
    bus.ofm_ready = 1'b1;
    #1;
    chk("ofm_valid", bus.ofm_valid, 1);
    chk("pe_reset_on_hs", bus.pe_reset, PE_ALL_ONES);
    if (bus.ofm_valid === 1'b1) outs++;
    tick;
    bus.pe_valid = '0;
    bus.ofm_ready = 1'b0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen_done;
    bus.start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.pe_valid = '0;
    bus.ofm_ready = 1'b0;
    bus.cfg_ifm_words = '0;
    bus.cfg_wgt_words = '0;
    bus.cfg_win_len = '0;
    bus.cfg_num_win = '0;
    repeat (3) tick;
    reset_n = 1'b1;
    tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_cal_start", bus.cal_start, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_done", bus.done, 0);
    // load 4 IFM then 2 weight words, then one 36-cycle window
    start_pass(4, 2, 36, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ifm_addr", bus.wr_addr, i);
      chk("ifm_we", {bus.we_ifm, bus.we_weight}, 2'b10);
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      chk("wgt_addr", bus.wr_addr, i);
      chk("wgt_we", {bus.we_ifm, bus.we_weight}, 2'b01);
      tick;
    end
    bus.ld_valid = 1'b0;
    #1;
    chk("prime_cal", {bus.cal_start, bus.ld_ready}, 2'b10);
    chk("prime_reset", bus.pe_reset, PE_ALL_ONES);
    tick;
    window(36, 0, 0);
    chk("done_pulse", bus.done, 1);
    tick;
    chk("done_one_cycle", {bus.done, bus.busy}, 2'b00);
    // three windows: partial pe_valid on the first, 5-cycle stall on the second
    outs = 0;
    start_pass(1, 1, 3, 3);
    skip_load(2);
    tick;
    window(3, 3, 0);
    window(3, 0, 5);
    window(3, 0, 0);
    chk("ofm_count", outs, 3);
    chk("done_3win", bus.done, 1);
    tick;
    chk("idle_3win", bus.busy, 0);
    // reset while RUN is at cycle 10
    start_pass(1, 1, 36, 1);
    skip_load(2);
    tick;
    repeat (10) tick;
    chk("mid_run", bus.cal_start, 1);
    reset_n = 1'b0;
    tick;
    chk("abort_outs", {bus.busy, bus.cal_start, bus.ld_ready, bus.done, bus.ofm_valid}, 5'b0);
    chk("abort_pe", {bus.pe_reset, bus.pe_finish}, 32'h0);
    reset_n = 1'b1;
    seen_done = 0;
    repeat (5) begin
      tick;
      seen_done |= int'(bus.done);
    end
    chk("abort_no_done", seen_done, 0);
    // start while busy is dropped, live cfg ignored, num_win=0 skips compute
    start_pass(3, 2, 4, 0);
    bus.start = 1'b1;
    bus.cfg_ifm_words = 16'd9;
    bus.cfg_num_win = 16'd5;
    tick;
    bus.start = 1'b0;
    #1;
    chk("busy_start_addr", bus.wr_addr, 1);
    tick;
    tick;
    chk("cfg_frozen", {bus.we_ifm, bus.we_weight}, 2'b01);
    tick;
    tick;
    bus.ld_valid = 1'b0;
    #1;
    chk("skip_done", {bus.done, bus.cal_start}, 2'b10);
    tick;
    chk("skip_idle", {bus.busy, bus.done}, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
